// File: rtl/seg_display_scanner.sv
// seg_display_scanner: multiplexed 8-digit common-anode 7-segment driver with double buffer
module seg_display_scanner #(
    parameter int CLK_FREQ     = 25000000,
    parameter int SCAN_FREQ    = 1000,
    parameter int BLANK_CYCLES = 250
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] value,
    input  logic [7:0]  dp,
    input  logic        lz_en,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp_n,
    output logic        frame_done
);
    localparam int SLOT = CLK_FREQ / SCAN_FREQ;
    localparam int CW = (SLOT > 1) ? $clog2(SLOT) : 1;
    localparam logic [CW-1:0] LAST = CW'(SLOT - 1);
    localparam logic [CW-1:0] BLANK_C = CW'(BLANK_CYCLES);
    localparam logic [6:0] SEG_LUT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef enum logic {BLANK, SHOW} state_t;

    state_t      state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [2:0]  idx;
    logic        wrap, frame_end;
    logic [31:0] act_val, sh_val;
    logic [7:0]  act_dp, sh_dp;
    logic        act_lz, sh_lz, pending;
    logic [7:0]  supp;
    logic        keep;
    logic [3:0]  nib;

    assign wrap      = cnt == LAST;
    assign frame_end = wrap && idx == 3'd7;
    assign cnt_next  = wrap ? '0 : cnt + 1'b1;
    assign nib       = act_val[{idx, 2'b00} +: 4];

    // Slot counter and digit index; the index advances on every slot wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= cnt_next;
            if (wrap) idx <= idx + 3'd1;
        end
    end

    // State register tracks which phase the current counter value is in
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= BLANK;
        else state <= state_next;
    end

    // Next state: blank for the first BLANK_CYCLES of each slot, show afterwards
    always_comb begin
        state_next = state;
        state_next = (cnt_next < BLANK_C) ? BLANK : SHOW;
    end

    // Shadow capture on load; transfer to active only at the frame boundary, a same-cycle load stays pending
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_val  <= '0;
            sh_dp   <= '0;
            sh_lz   <= 1'b0;
            act_val <= '0;
            act_dp  <= '0;
            act_lz  <= 1'b0;
            pending <= 1'b0;
        end else begin
            if (load) begin
                sh_val <= value;
                sh_dp  <= dp;
                sh_lz  <= lz_en;
            end
            if (frame_end && pending) begin
                act_val <= sh_val;
                act_dp  <= sh_dp;
                act_lz  <= sh_lz;
            end
            pending <= load | (pending & ~frame_end);
        end
    end

    // Leading-zero mask: scanning down from digit 7, stop suppressing at the first nonzero digit or lit dp
    always_comb begin
        keep = 1'b0;
        supp = '0;
        for (int i = 7; i > 0; i--) begin
            keep = keep | (act_val[4*i +: 4] != 4'd0) | act_dp[i];
            supp[i] = act_lz & ~keep;
        end
    end

    // Registered display outputs, one cycle behind the counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an         <= 8'hFF;
            seg        <= 7'h7F;
            dp_n       <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            an         <= (state == SHOW) ? ~(8'd1 << idx) : 8'hFF;
            seg        <= (state == SHOW && !supp[idx]) ? SEG_LUT[nib] : 7'h7F;
            dp_n       <= (state == SHOW) ? (supp[idx] | ~act_dp[idx]) : 1'b1;
            frame_done <= frame_end;
        end
    end
endmodule

// File: tb/tb_seg_display_scanner.sv
// tb_seg_display_scanner: random and directed stimulus against a frame-level reference model
module tb_seg_display_scanner;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [31:0] value = '0;
    logic [7:0]  dp = '0;
    logic        lz_en = 1'b0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp_n;
    logic        frame_done;

    int total = 0;
    int bad = 0;
    int n = 0;
    int le[$];
    logic [31:0] lv[$];
    logic [7:0]  ldp[$];
    logic        llz[$];

    logic [6:0] lut [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    seg_display_scanner #(.CLK_FREQ(16), .SCAN_FREQ(1), .BLANK_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .load(load), .value(value), .dp(dp), .lz_en(lz_en),
        .an(an), .seg(seg), .dp_n(dp_n), .frame_done(frame_done)
    );

    // 10-unit clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s n=%0d got=%h exp=%h", tag, n, got, exp);
        end
    endtask

    // Outputs after edge n show counter time t=n-1; a frame shows the last load made before it began
    task automatic check();
        int t, pos, d, fs;
        logic [31:0] v;
        logic [7:0] dv, e_an;
        logic z, blank;
        logic [6:0] e_seg;
        logic e_dpn;
        v = '0; dv = '0; z = 1'b0;
        if (n == 0) begin
            e_an = 8'hFF; e_seg = 7'h7F; e_dpn = 1'b1;
        end else begin
            t = n - 1;
            pos = t % 16;
            d = (t / 16) % 8;
            fs = 128 * (t / 128);
            foreach (le[i]) if (le[i] < fs) begin v = lv[i]; dv = ldp[i]; z = llz[i]; end
            blank = z && d > 0 && (v >> (4 * d)) == 0 && (dv >> d) == 0;
            if (pos < 4) begin
                e_an = 8'hFF; e_seg = 7'h7F; e_dpn = 1'b1;
            end else begin
                e_an = ~(8'd1 << d);
                e_seg = blank ? 7'h7F : lut[(v >> (4 * d)) & 32'hF];
                e_dpn = blank ? 1'b1 : ~dv[d];
            end
        end
        chk("an", an, e_an);
        chk("seg", {1'b0, seg}, {1'b0, e_seg});
        chk("dp_n", {7'd0, dp_n}, {7'd0, e_dpn});
        chk("frame_done", {7'd0, frame_done}, {7'd0, n > 0 && n % 128 == 0});
    endtask

    task automatic cyc(input logic ld, input logic [31:0] v, input logic [7:0] d, input logic z);
        load = ld; value = v; dp = d; lz_en = z;
        @(posedge clk);
        n++;
        if (ld) begin le.push_back(n); lv.push_back(v); ldp.push_back(d); llz.push_back(z); end
        #1 load = 1'b0;
        check();
    endtask

    task automatic run_to(input int target);
        while (n < target) cyc(1'b0, $urandom, $urandom, 1'($urandom));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        n = 0;
        le.delete(); lv.delete(); ldp.delete(); llz.delete();
        chk("rst_an", an, 8'hFF);
        chk("rst_seg", {1'b0, seg}, 8'h7F);
        chk("rst_dpn", {7'd0, dp_n}, 8'd1);
        chk("rst_fd", {7'd0, frame_done}, 8'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        check();
    endtask

    initial begin
        int guard;
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        run_to(39);
        cyc(1'b1, 32'h89ABCDEF, 8'h00, 1'b0);
        run_to(299);
        cyc(1'b1, 32'h00000305, 8'h00, 1'b1);
        run_to(429);
        cyc(1'b1, 32'h00000305, 8'h10, 1'b1);
        run_to(559);
        cyc(1'b1, 32'h00000000, 8'h00, 1'b1);
        run_to(720);
        cyc(1'b1, $urandom, 8'h00, 1'b0);
        cyc(1'b0, 32'h0, 8'h0, 1'b0);
        cyc(1'b1, $urandom >> 12, 8'h00, 1'b1);
        run_to(1023);
        cyc(1'b1, 32'h00C0FFEE, 8'h01, 1'b1);
        run_to(1400);
        repeat (1500) begin
            if ($urandom_range(0, 19) == 0)
                cyc(1'b1, $urandom >> (4 * $urandom_range(0, 7)),
                    ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00, 1'($urandom));
            else
                cyc(1'b0, $urandom, $urandom, 1'($urandom));
        end
        cyc(1'b1, 32'h12345678, 8'hFF, 1'b0);
        guard = 0;
        while (!(((n - 1) % 128) / 16 == 5 && (n - 1) % 16 >= 8) && guard < 300) begin
            cyc(1'b0, 32'h0, 8'h0, 1'b0);
            guard++;
        end
        chk("reach_digit5", {7'd0, guard < 300}, 8'd1);
        cyc(1'b1, 32'hDEADBEEF, 8'hAA, 1'b0);
        #2;
        do_reset();
        run_to(300);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seg_display_scanner.md
Name: seg_display_scanner

Overview:
- Multiplexed driver for an 8-digit, common-anode 7-segment display. Shows the calculator's operand or result as 8 hex digits.
- It is the output-side counterpart of the keypad matrix scanner. It drives digit-select lines in a rotating scan and presents segment patterns for each digit.
- A double buffer gives tear-free updates. A per-digit blanking gap suppresses ghosting. Optional leading-zero suppression.

Parameters:
- CLK_FREQ, 25000000, system clock frequency in Hz.
- SCAN_FREQ, 1000, digit slots per second. Slot length is SLOT = CLK_FREQ/SCAN_FREQ cycles; must be ≥ BLANK_CYCLES+2.
- BLANK_CYCLES, 250, cycles at the start of each slot with all digits off.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- load  input  1  one-cycle strobe; captures value/dp/lz_en into the shadow buffer.
- value  input  32  8 hex digits; digit i = value[4i+3:4i], digit 0 least significant.
- dp  input  8  decimal point per digit, 1 = lit.
- lz_en  input  1  leading-zero suppression enable, captured with load.
- an  output  8  digit selects, active-low; an[i] drives digit i.
- seg  output  7  {g,f,e,d,c,b,a}, active-low.
- dp_n  output  1  decimal point, active-low.
- frame_done  output  1  one-cycle pulse when digit 7's slot ends.

Behaviour:
- Reset (asynchronous, while high):
  - an=8'hFF, seg=7'h7F, dp_n=1, frame_done=0.
  - slot counter=0, digit index=0, state=BLANK.
  - Active and shadow buffers cleared (value 0, dp 0, lz_en 0); pending=0.
- Counters:
  - Slot counter runs 0..SLOT-1 and wraps.
  - On wrap, the digit index advances 0→1→…→7→0.
- State machine, evaluated per cycle:
  - BLANK while counter < BLANK_CYCLES: an=8'hFF, seg=7'h7F, dp_n=1.
  - SHOW otherwise: an has only bit [index] low; seg/dp_n show the active buffer's digit[index].
  - BLANK→SHOW at counter==BLANK_CYCLES.
  - SHOW→BLANK at the counter wrap, together with the index advance.
- Outputs are registered: they reflect state/index from the previous cycle, a 1-cycle lag relative to the counters.
- Segment decode (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Leading-zero suppression (when the active lz_en=1):
  - Digit i (i=7..1) is blanked if it and all higher digits are 0. Blanked means seg=7'h7F, dp_n=1, an still asserted.
  - Digit 0 is never suppressed.
  - A digit with its dp bit set is never suppressed, and neither is any digit below it.
- Double buffer:
  - load writes the shadow and sets pending.
  - A second load before transfer overwrites the shadow; the last write wins.
  - Transfer (shadow→active, pending←0) happens on the cycle the index wraps 7→0. The next frame therefore starts digit 0 with the new data.
  - A load in the same cycle as the transfer is not transferred; it stays pending until the following frame boundary.
- frame_done:
  - Asserted for exactly one cycle on the 7→0 wrap, every frame, whether or not a transfer occurs.
- Reset mid-slot or mid-frame: all outputs go to reset values immediately and pending data is lost.
- Arithmetic:
  - Counter width is clog2(SLOT).
  - The index is 3 bits and wraps naturally.
  - No other overflow conditions exist.

Test Plan:
- Reset and first frame. Params CLK_FREQ=16, SCAN_FREQ=1, BLANK_CYCLES=4; pulse reset.
  - Outputs hold an=FF, seg=7F, dp_n=1.
  - After release: 4 blank cycles, then an=FE, seg=1000000 for 12 cycles, then digit 1.
  - frame_done pulses once every 128 cycles.
- Full decode. Load value=32'h89ABCDEF, dp=8'h00, lz_en=0 mid-frame.
  - The old value shows until the frame ends.
  - Next frame: digit0 seg=0001110 (F), digit3 seg=1000110 (C), digit7 seg=0000000 (8), with an bits walking FE,FD,…,7F.
- Leading zeros. Load value=32'h00000305, lz_en=1, dp=0.
  - Digits 7..3 show seg=7F with their an asserted.
  - Digit2=0110000 (3), digit1=1000000 (0), digit0=0010010 (5).
  - Repeat with dp=8'h10: digits 4..1 display, digit4 has dp_n=0.
- Zero value. Load value=0, lz_en=1: only digit0 lit with 1000000; all others blank.
- Load collisions.
  - Load A, then load B two cycles later, same frame: the next frame shows only B.
  - Load C on the exact 7→0 wrap cycle: the current frame shows the old data; C appears one frame later; frame_done still pulses.
- Reset mid-operation. Assert reset during digit 5 SHOW with pending load.
  - an=FF, seg=7F immediately.
  - After release: digit 0 shows 0 (1000000); the pending value never appears.
